// File: rtl/pong_game_ctrl.sv
// Game-flow controller for the VGA pong datapath: attract/serve/play/over sequencing, miss detection,
// BCD score and lives. Optional paddle-hit speed-up is enabled by defining PONG_SPEEDUP_EN.
module pong_game_ctrl #(
  parameter int LIVES            = 3,
  parameter int SERVE_DELAY      = 60,
  parameter int MISS_Y           = 464,
  parameter int SERVE_X          = 312,
  parameter int SERVE_Y          = 64,
  parameter int HITS_PER_SPEEDUP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [8:0] ball_y,
  input  logic       paddle_hit,
  output logic       ball_run,
  output logic       ball_load,
  output logic [9:0] serve_x,
  output logic [8:0] serve_y,
  output logic       serve_dir_x,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [2:0] state,
  output logic [1:0] ball_step
);

  // Handshake with the ball datapath: ball_run is a level that permits motion on each frame_tick;
  // ball_load is a single-cycle command to latch serve_x/serve_y/serve_dir_x, never asserted twice in a row.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    OVER  = 3'd3
  } stateT;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] DELAY_INIT = 8'(SERVE_DELAY);
  localparam logic [8:0] MISS_LIMIT = 9'(MISS_Y);

  stateT      stateQ, stateD;
  logic       ballRunQ, ballRunD;
  logic       ballLoadQ, ballLoadD;
  logic       serveDirQ, serveDirD;
  logic [7:0] scoreQ, scoreD;
  logic [1:0] livesQ, livesD;
  logic       gameOverQ, gameOverD;
  logic [7:0] cntQ, cntD;
  logic       startSync1, startSync2, startPrev;
  logic       startEdge;
  logic       missNow;

`ifdef PONG_SPEEDUP_EN
  localparam int HCW = $clog2(HITS_PER_SPEEDUP) + 1;
  localparam logic [HCW-1:0] HITS_LAST = HCW'(HITS_PER_SPEEDUP - 1);
  logic [HCW-1:0] hitCntQ, hitCntD;
  logic [1:0]     stepQ, stepD;
`endif

  // Saturating two-digit BCD increment.
  function automatic logic [7:0] bcdInc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99)
      r = s;
    else if (s[3:0] == 4'd9)
      r = {s[7:4] + 4'd1, 4'd0};
    else
      r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      startSync1 <= 1'b0;
      startSync2 <= 1'b0;
      startPrev  <= 1'b0;
    end else begin
      startSync1 <= start_btn;
      startSync2 <= startSync1;
      startPrev  <= startSync2;
    end
  end

  assign startEdge = startSync2 & ~startPrev;
  assign missNow   = frame_tick && (ball_y >= MISS_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ    <= IDLE;
      ballRunQ  <= 1'b0;
      ballLoadQ <= 1'b0;
      serveDirQ <= 1'b0;
      scoreQ    <= 8'h00;
      livesQ    <= LIVES_INIT;
      gameOverQ <= 1'b0;
      cntQ      <= 8'd0;
`ifdef PONG_SPEEDUP_EN
      hitCntQ   <= '0;
      stepQ     <= 2'd1;
`endif
    end else begin
      stateQ    <= stateD;
      ballRunQ  <= ballRunD;
      ballLoadQ <= ballLoadD;
      serveDirQ <= serveDirD;
      scoreQ    <= scoreD;
      livesQ    <= livesD;
      gameOverQ <= gameOverD;
      cntQ      <= cntD;
`ifdef PONG_SPEEDUP_EN
      hitCntQ   <= hitCntD;
      stepQ     <= stepD;
`endif
    end
  end

  always_comb begin
    stateD    = stateQ;
    ballRunD  = 1'b0;
    ballLoadD = 1'b0;
    scoreD    = scoreQ;
    livesD    = livesQ;
    cntD      = cntQ;
`ifdef PONG_SPEEDUP_EN
    hitCntD   = hitCntQ;
    stepD     = stepQ;
`endif
    case (stateQ)
      IDLE, OVER: begin
        if (startEdge) begin
          scoreD    = 8'h00;
          livesD    = LIVES_INIT;
          ballLoadD = 1'b1;
          cntD      = DELAY_INIT;
          stateD    = SERVE;
`ifdef PONG_SPEEDUP_EN
          hitCntD   = '0;
          stepD     = 2'd1;
`endif
        end
      end
      SERVE: begin
        if (frame_tick) begin
          cntD = cntQ - 8'd1;
          if (cntQ == 8'd1) begin
            stateD   = PLAY;
            ballRunD = 1'b1;
          end
        end
      end
      PLAY: begin
        ballRunD = 1'b1;
        if (paddle_hit) begin
          scoreD = bcdInc(scoreQ);
`ifdef PONG_SPEEDUP_EN
          if (hitCntQ == HITS_LAST) begin
            hitCntD = '0;
            if (stepQ != 2'd3) stepD = stepQ + 2'd1;
          end else begin
            hitCntD = hitCntQ + 1'b1;
          end
`endif
        end
        // A hit in the same cycle as a miss is still scored above.
        if (missNow) begin
          ballRunD = 1'b0;
          livesD   = livesQ - 2'd1;
          if (livesQ == 2'd1) begin
            stateD = OVER;
          end else begin
            ballLoadD = 1'b1;
            cntD      = DELAY_INIT;
            stateD    = SERVE;
          end
        end
      end
      default: stateD = IDLE;
    endcase
    serveDirD = serveDirQ ^ ballLoadD;
    gameOverD = (stateD == OVER);
  end

  assign ball_run    = ballRunQ;
  assign ball_load   = ballLoadQ;
  assign serve_x     = 10'(SERVE_X);
  assign serve_y     = 9'(SERVE_Y);
  assign serve_dir_x = serveDirQ;
  assign score       = scoreQ;
  assign lives       = livesQ;
  assign game_over   = gameOverQ;
  assign state       = stateQ;
`ifdef PONG_SPEEDUP_EN
  assign ball_step   = stepQ;
`else
  assign ball_step   = 2'd1;
`endif

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-flow controller for the VGA pong datapath. It sequences attract, serve, play and game-over phases, and gates ball motion through a run/load handshake with the ball-position logic. It detects misses below the paddle row and keeps BCD score and remaining lives. It sits beside the ball/paddle datapath and is clocked by the same pixel clock, advancing on the per-frame ball-update strobe.

## Interface
Parameters:
- LIVES, 3: balls per game (1-3).
- SERVE_DELAY, 60: frames the ball is held before play starts (1-255).
- MISS_Y, 464: ball top Y at or beyond which the ball counts as missed.
- SERVE_X, 312: ball X loaded on serve.
- SERVE_Y, 64: ball Y loaded on serve.
- HITS_PER_SPEEDUP, 8: paddle hits per speed step (PONG_SPEEDUP_EN only).

Ports:
- clk, in, 1: pixel clock; sole clock.
- reset, in, 1: asynchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse per frame, coincident with the ball-update strobe.
- start_btn, in, 1: raw asynchronous start button.
- ball_y, in, 9: current ball top Y.
- paddle_hit, in, 1: one-cycle pulse when the ball bounces off the paddle.
- ball_run, out, 1: datapath may move the ball on frame_tick.
- ball_load, out, 1: one-cycle pulse; datapath loads serve_x, serve_y and serve_dir_x.
- serve_x, out, 10: equals SERVE_X.
- serve_y, out, 9: equals SERVE_Y.
- serve_dir_x, out, 1: X direction for the next serve (0 = right).
- score, out, 8: two BCD digits, {tens, ones}.
- lives, out, 2: balls remaining.
- game_over, out, 1: high in OVER state.
- state, out, 3: IDLE=0, SERVE=1, PLAY=2, OVER=3.
- ball_step, out, 2: pixels per frame for the ball.

## Operation
- Start button path: 2-flop synchronizer, then a previous-level register. start_edge = sync & ~prev.
- IDLE: ball_run=0. start_edge loads score=0 and lives=LIVES, pulses ball_load, loads frame counter with SERVE_DELAY, and goes to SERVE.
- SERVE: ball_run=0. Each frame_tick decrements the counter. A frame_tick seen with counter==1 goes to PLAY and sets ball_run=1.
- PLAY: ball_run=1. paddle_hit increments score in BCD, ones 9→0 with carry into tens. Score saturates at 0x99.
- Miss: evaluated only on frame_tick, when ball_y >= MISS_Y (unsigned 9-bit compare). Clears ball_run and decrements lives.
  - If the new lives is 0: go to OVER.
  - Otherwise: pulse ball_load, reload the counter and go to SERVE.
- OVER: game_over=1, ball_run=0. start_edge behaves as in IDLE.
- serve_dir_x toggles on every ball_load pulse, so serves alternate left and right.
- Ignored inputs:
  - start_edge in SERVE or PLAY.
  - paddle_hit outside PLAY.
  - frame_tick in IDLE or OVER.
- Simultaneous paddle_hit and miss frame_tick in PLAY: the hit is scored and the miss is also taken.
- Reset values (any state, mid-game included): state=IDLE, ball_run=0, ball_load=0, serve_dir_x=0, score=0x00, lives=LIVES, game_over=0, counter=0, synchronizer flops=0, ball_step=1.

## Timing
- All outputs are registered. Every state transition takes effect on the clock edge that samples its cause.
- start_btn rising and stable before edge k → ball_load is high for exactly one cycle after edge k+2. state=SERVE from that same cycle.
- Miss frame_tick sampled at edge n:
  - ball_run=0 and lives decremented after edge n.
  - ball_load is high after edge n in the same cycle, when lives remain.
- SERVE hold is exactly SERVE_DELAY frame_ticks. ball_run rises after the edge that samples the SERVE_DELAY-th tick.
- paddle_hit sampled at edge n → score updated after edge n.
- ball_load never asserts in two consecutive cycles.

## Configuration
- PONG_SPEEDUP_EN defined:
  - A hit counter of width clog2(HITS_PER_SPEEDUP)+1 counts paddle_hit in PLAY.
  - On reaching HITS_PER_SPEEDUP, the counter clears and ball_step increments, saturating at 3.
  - Hit counter and ball_step reset to 0 and 1 on start_edge and on reset. A miss does not reset them.
- PONG_SPEEDUP_EN undefined: no hit counter; ball_step is constant 1.

## Test plan
- Reset asserted mid-PLAY with score=0x12 and lives=2 → next cycle: state=0, score=0x00, lives=3, ball_run=0, game_over=0.
- start_btn pulse in IDLE → exactly one ball_load pulse 3 edges later, serve_dir_x toggles to 1, and ball_run rises after the 60th frame_tick.
- In PLAY, 11 paddle_hit pulses from score=0x95 → score=0x99 and holds; after 5 hits score=0x99, not 0xA0.
- Three frame_ticks with ball_y=464 (serve delay between each) → lives 3→2→1→0, two ball_load pulses, then state=3, game_over=1. A further start_btn restarts with score=0 and lives=3.
- ball_y=463 on frame_tick → no miss. paddle_hit and a miss frame_tick in the same cycle → score+1 and lives-1.
- With PONG_SPEEDUP_EN: 8 hits → ball_step=2, 24 hits → ball_step=3, and it stays 3 after 32 hits. Without the macro, ball_step=1 throughout.
